// File: rtl/except_ctrl_pkg.sv
// Shared exception-controller constants: CP0 event codes, FSM states and the
// default handler entry address.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0040;

  localparam logic [31:0] EXCTYPE_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXCTYPE_INT     = 32'h0000_0004;
  localparam logic [31:0] EXCTYPE_SYSCALL = 32'h0000_0100;
  localparam logic [31:0] EXCTYPE_ERET    = 32'h0000_0200;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTER,
    ST_REDIRECT
  } exc_state_e;

endpackage

// File: rtl/except_ctrl.sv
// Commit-stage exception controller: accepts interrupt/syscall/eret, reports
// the event to CP0 for one cycle, then flushes and redirects fetch.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic        is_syscall,
  input  logic        is_eret,
  input  logic [31:0] status,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  input  logic        intimer,
  output logic [31:0] excptype,
  output logic [31:0] excpc,
  output logic        flush,
  output logic [31:0] newpc,
  output logic        newpc_valid
);

  exc_state_e  r_state;
  logic        r_int_pend;
  logic [31:0] r_target;

  logic        w_int_req;
  logic        w_idle_valid;
  logic        w_accept_int;
  logic        w_accept_sys;
  logic        w_accept_eret;
  logic        w_unused_bits;

  assign w_unused_bits = ^{status[31:16], status[9:2], cause[31:16], cause[9:0]};

  always_comb begin
    w_int_req     = status[0] & ~status[1] &
                    ((|(cause[15:10] & status[15:10])) | (intimer & status[15]));
    w_idle_valid  = (r_state == ST_IDLE) & inst_valid;
    w_accept_int  = w_idle_valid & r_int_pend;
    w_accept_sys  = w_idle_valid & ~r_int_pend & is_syscall;
    w_accept_eret = w_idle_valid & ~r_int_pend & ~is_syscall & is_eret;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_int_pend  <= 1'b0;
      r_target    <= '0;
      excptype    <= EXCTYPE_NONE;
      excpc       <= '0;
      flush       <= 1'b0;
      newpc       <= '0;
      newpc_valid <= 1'b0;
    end else begin
      // Pending interrupt only arms in IDLE but drops whenever the request goes away.
      if (w_accept_int || !w_int_req)
        r_int_pend <= 1'b0;
      else if (r_state == ST_IDLE)
        r_int_pend <= 1'b1;

      excptype    <= EXCTYPE_NONE;
      excpc       <= '0;
      flush       <= 1'b0;
      newpc_valid <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_accept_int || w_accept_sys || w_accept_eret) begin
            r_state  <= ST_ENTER;
            flush    <= 1'b1;
            excpc    <= inst_pc;
            r_target <= w_accept_eret ? epc : EXC_VECTOR;
            if (w_accept_int)
              excptype <= EXCTYPE_INT;
            else if (w_accept_sys)
              excptype <= EXCTYPE_SYSCALL;
            else
              excptype <= EXCTYPE_ERET;
          end
        end
        ST_ENTER: begin
          r_state     <= ST_REDIRECT;
          flush       <= 1'b1;
          newpc       <= r_target;
          newpc_valid <= 1'b1;
        end
        ST_REDIRECT: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: directed scenarios plus random traffic checked against
// a cycle-countdown reference model.
module tb_except_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        is_syscall;
  logic        is_eret;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        intimer;
  logic [31:0] excptype;
  logic [31:0] excpc;
  logic        flush;
  logic [31:0] newpc;
  logic        newpc_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: m_cnt counts the cycles of the flush/redirect sequence still to run.
  int          m_cnt;
  bit          m_pend;
  logic [31:0] m_type, m_excpc, m_newpc, m_target;
  bit          m_flush, m_nv;

  except_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .is_syscall(is_syscall), .is_eret(is_eret), .status(status), .cause(cause),
    .epc(epc), .intimer(intimer), .excptype(excptype), .excpc(excpc),
    .flush(flush), .newpc(newpc), .newpc_valid(newpc_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge();
    bit ireq;
    logic [31:0] code;
    if (rst) begin
      m_cnt = 0; m_pend = 0; m_type = 0; m_excpc = 0;
      m_flush = 0; m_nv = 0; m_newpc = 0; m_target = 0;
      return;
    end
    ireq = status[0] && !status[1] &&
           (((cause[15:10] & status[15:10]) != 6'd0) || (intimer && status[15]));
    if (m_cnt == 0 && inst_valid && (m_pend || is_syscall || is_eret)) begin
      code     = m_pend ? 32'h4 : (is_syscall ? 32'h100 : 32'h200);
      m_target = (code == 32'h200) ? epc : VEC;
      m_type   = code;
      m_excpc  = inst_pc;
      m_flush  = 1; m_nv = 0;
      m_pend   = (code == 32'h4) ? 1'b0 : ireq;
      m_cnt    = 2;
    end else if (m_cnt == 2) begin
      m_type = 0; m_excpc = 0; m_flush = 1; m_nv = 1; m_newpc = m_target;
      m_pend = ireq && m_pend;
      m_cnt  = 1;
    end else if (m_cnt == 1) begin
      m_type = 0; m_excpc = 0; m_flush = 0; m_nv = 0;
      m_pend = ireq && m_pend;
      m_cnt  = 0;
    end else begin
      m_type = 0; m_excpc = 0; m_flush = 0; m_nv = 0;
      m_pend = ireq;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("excptype", excptype, m_type);
    check("excpc", excpc, m_excpc);
    check("flush", {31'd0, flush}, {31'd0, m_flush});
    check("newpc", newpc, m_newpc);
    check("newpc_valid", {31'd0, newpc_valid}, {31'd0, m_nv});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_valid = 0; is_syscall = 0; is_eret = 0; intimer = 0;
    status = 32'h0000_0001; cause = '0;
  endtask

  initial begin
    rst = 1; inst_pc = '0; epc = '0;
    idle_inputs();
    @(negedge clk);

    // Reset state
    tick();
    check("rst_excptype", excptype, 32'h0);
    check("rst_newpc_valid", {31'd0, newpc_valid}, 32'd0);
    rst = 0;

    // Timer interrupt: arm the pending flag, then commit at 0x100
    status = 32'h0000_8001; intimer = 1;
    tick();
    inst_valid = 1; inst_pc = 32'h100;
    tick();
    check("int_type", excptype, 32'h4);
    check("int_excpc", excpc, 32'h100);
    check("int_flush1", {31'd0, flush}, 32'd1);
    inst_valid = 0; intimer = 0;
    tick();
    check("int_newpc", newpc, 32'h40);
    check("int_nv", {31'd0, newpc_valid}, 32'd1);
    check("int_flush2", {31'd0, flush}, 32'd1);
    check("int_type_clr", excptype, 32'h0);
    tick();
    check("int_flush_off", {31'd0, flush}, 32'd0);

    // Syscall
    idle_inputs(); inst_valid = 1; is_syscall = 1; inst_pc = 32'h200;
    tick();
    check("sys_type", excptype, 32'h100);
    check("sys_excpc", excpc, 32'h200);
    idle_inputs();
    tick();
    check("sys_newpc", newpc, 32'h40);
    tick();

    // Eret, epc changes after the accepting edge
    inst_valid = 1; is_eret = 1; epc = 32'h204; inst_pc = 32'h300;
    tick();
    check("eret_type", excptype, 32'h200);
    idle_inputs(); epc = 32'hDEAD_0000;
    tick();
    check("eret_newpc", newpc, 32'h204);
    check("eret_nv", {31'd0, newpc_valid}, 32'd1);
    tick();
    check("hold_newpc", newpc, 32'h204);

    // EXL masks the interrupt
    status = 32'h0000_8003; intimer = 1; inst_valid = 1; inst_pc = 32'h500;
    tick();
    tick();
    check("exl_type", excptype, 32'h0);
    check("exl_flush", {31'd0, flush}, 32'd0);

    // Interrupt and syscall together: interrupt only
    status = 32'h0000_8001; inst_valid = 0;
    tick();
    inst_valid = 1; is_syscall = 1; inst_pc = 32'h600;
    tick();
    check("coinc_type", excptype, 32'h4);
    idle_inputs();
    tick();
    tick();

    // Second syscall during ENTER is ignored
    inst_valid = 1; is_syscall = 1; inst_pc = 32'h400;
    tick();
    inst_pc = 32'h404;
    tick();
    check("enter_ign_type", excptype, 32'h0);
    check("enter_ign_newpc", newpc, 32'h40);
    idle_inputs();
    tick();
    check("enter_ign_flush", {31'd0, flush}, 32'd0);

    // Reset during ENTER aborts the sequence
    inst_valid = 1; is_eret = 1; epc = 32'h0000_0888; inst_pc = 32'h700;
    tick();
    idle_inputs(); rst = 1;
    tick();
    check("abort_flush", {31'd0, flush}, 32'd0);
    check("abort_newpc", newpc, 32'h0);
    rst = 0;
    tick();
    check("abort_nv", {31'd0, newpc_valid}, 32'd0);
    check("abort_type", excptype, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      inst_valid = $urandom_range(0, 3) != 0;
      is_syscall = $urandom_range(0, 5) == 0;
      is_eret    = $urandom_range(0, 5) == 0;
      intimer    = $urandom_range(0, 3) == 0;
      status     = {16'd0, 6'($urandom), 8'd0,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
      cause      = {16'd0, ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0, 10'd0};
      inst_pc    = $urandom;
      epc        = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0040, handler entry address used for interrupt and syscall redirect.
REQ-002 SHALL have clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have inst_valid  input  1  committing instruction present this cycle (0 = bubble/stall).
REQ-005 SHALL have inst_pc  input  32  address of committing instruction.
REQ-006 SHALL have is_syscall  input  1  committing instruction is SYSCALL; ignored when inst_valid=0.
REQ-007 SHALL have is_eret  input  1  committing instruction is ERET; ignored when inst_valid=0.
REQ-008 SHALL have status  input  32  CP0 Status (bit0 IE, bit1 EXL, bits15:10 IM).
REQ-009 SHALL have cause  input  32  CP0 Cause (bits15:10 IP).
REQ-010 SHALL have epc  input  32  CP0 EPC value.
REQ-011 SHALL have intimer  input  1  CP0 timer interrupt, mapped to IM bit 15.
REQ-012 SHALL have excptype  output  32  one-hot event code to CP0: 32'h0000_0004 interrupt, 32'h0000_0100 syscall, 32'h0000_0200 eret, 0 none.
REQ-013 SHALL have excpc  output  32  PC handed to CP0 with excptype.
REQ-014 SHALL have flush  output  1  kill all in-flight pipeline stages.
REQ-015 SHALL have newpc  output  32  fetch redirect target.
REQ-016 SHALL have newpc_valid  output  1  one-cycle redirect strobe.

Function
REQ-017 SHALL compute int_req = IE & ~EXL & ( |(cause[15:10] & status[15:10]) | (intimer & status[15]) ).
REQ-018 SHALL hold register int_pend: set when int_req=1 in IDLE, cleared on interrupt acceptance or when int_req=0.
REQ-019 SHALL implement FSM IDLE, ENTER, REDIRECT; IDLE->ENTER on acceptance, ENTER->REDIRECT, REDIRECT->IDLE unconditionally.
REQ-020 SHALL accept an event only in IDLE with inst_valid=1; priority interrupt (int_pend) > syscall > eret.
REQ-021 SHALL, on acceptance at edge N, drive excptype and excpc for exactly cycle N+1 (state ENTER), else excptype=0.
REQ-022 SHALL set excpc = inst_pc for interrupt and syscall (CP0 adds 4 for syscall), excpc = inst_pc for eret (unused by CP0).
REQ-023 SHALL assert flush in ENTER and REDIRECT (two cycles), deasserted otherwise.
REQ-024 SHALL assert newpc_valid only in REDIRECT; newpc = EXC_VECTOR for interrupt/syscall, epc sampled at acceptance edge for eret.
REQ-025 SHALL ignore is_syscall, is_eret and int_req outside IDLE; int_pend SHALL NOT be set during ENTER/REDIRECT.
REQ-026 SHALL, when interrupt and syscall coincide, take interrupt only; syscall is re-presented by pipeline after handler returns.
REQ-027 SHALL accept eret regardless of EXL value.
REQ-028 SHALL hold newpc at its last value when newpc_valid=0.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force state IDLE, int_pend=0, excptype=0, excpc=0, flush=0, newpc=0, newpc_valid=0.
REQ-030 SHALL abort any ENTER/REDIRECT sequence on reset; no excptype or redirect emitted afterwards.

Structure
REQ-031 SHALL place excptype codes, FSM state encodings and EXC_VECTOR default in shared define.v alongside existing CP0 constants.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 SHALL test: status=32'h0000_8001, intimer=1, inst_valid=1, inst_pc=32'h100 -> cycle+1 excptype=4, excpc=32'h100; cycle+2 newpc=32'h40, newpc_valid=1; flush 2 cycles.
REQ-034 SHALL test: is_syscall=1, inst_pc=32'h200, no interrupt -> excptype=32'h100, excpc=32'h200, newpc=32'h40.
REQ-035 SHALL test: is_eret=1, epc=32'h204 -> excptype=32'h200, newpc=32'h204 on redirect cycle.
REQ-036 SHALL test: status=32'h0000_8003 (EXL=1), intimer=1 -> no event; syscall+interrupt same cycle with EXL=0 -> excptype=4 only.
REQ-037 SHALL test: second syscall presented during ENTER -> ignored; rst=1 during ENTER -> next cycle all outputs 0, no newpc_valid.
